uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART link; it consumes the 11-bit frames produced by the UART transmitter stage. Frame format: start (0), 8 data bits LSB first, even parity bit (XOR of the 8 data bits), stop (1). The block synchronises the line, validates start, parity and stop, and presents each received byte with a one-cycle valid strobe and error flags to the downstream consumer.

## Interface

- CLK_FREQ, 50000: system clock frequency (Hz).
- BAUD_RATE, 10000: line rate (baud).
- Derived N = 2*(CLK_FREQ/(BAUD_RATE*2)) clocks per bit, integer division at each step; 4 with defaults. HALF = N/2. Constraint: N >= 4.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last received byte.
- valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on last frame.
- frame_err  output  1  stop bit sampled 0 on last frame.
- busy  output  1  high whenever state != IDLE.

## Operation

- rx passes through a 2-flop synchroniser (rx_s). Both flops reset to 1, so reset never produces a false start.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. Counter cnt counts clocks within a bit; bit index counts 0..7.
- IDLE: rx_s==0 -> START, cnt=0.
- START: cnt increments each cycle. At cnt==HALF-1:
  - rx_s==0 -> DATA, cnt=0, index=0.
  - rx_s==1 -> IDLE (glitch rejected, no output change).
- DATA: at cnt==N-1, sample rx_s into the shift register and clear cnt. The shift register shifts right and the new bit enters bit 7, so bit 0 ends up LSB. After index 7 -> PARITY.
- PARITY: at cnt==N-1, store p = rx_s ^ (XOR of shift register) -> STOP.
- STOP: at cnt==N-1, on the same edge:
  - data <= shift register; parity_err <= p; frame_err <= ~rx_s; valid <= 1.
  - rx_s==1 -> IDLE. rx_s==0 -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a break/low line from retriggering.
- Sampling lands mid-bit; the stop-bit sample occurs mid-stop-bit, so a new start edge right after it is accepted.
- data, parity_err and frame_err hold their values until the next valid. They update even when errors are flagged.
- An error frame still pulses valid. The consumer qualifies with the flags.

## Timing

- Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0. State is IDLE, cnt=0, shift register 0.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded with no valid.
- Let e0 be the clk edge where the first sync flop captures rx low.
  - IDLE->START occurs at e0+2.
  - START->DATA occurs at e0+2+HALF.
  - Data bit k is sampled at e0+2+HALF+(k+1)*N.
  - valid is high during the cycle after edge e0+2+HALF+10*N, which is e0+44 with defaults.
- valid is exactly one cycle wide. Back-to-back frames produce valids 11*N cycles apart (44 with defaults) with no loss.
- A low pulse shorter than HALF clocks after synchronisation is rejected. busy returns to 0 at e0+2+HALF.
- Counter width: ceil(log2(N)) bits; it never wraps past N-1.

## Test plan

- Reset then rx=1 for 200 cycles -> all outputs 0, busy 0, no valid.
- Frame 0xA5, parity 0, stop 1, 4 clk/bit -> valid one cycle at e0+44, data=0xA5, parity_err=0, frame_err=0, busy 0 afterwards.
- Frame 0x01 with parity bit 0 (wrong) -> valid, data=0x01, parity_err=1, frame_err=0. Next good frame 0x03 (parity 0) -> parity_err clears to 0.
- Frame 0x3C with stop bit 0, line held low 20 cycles, then high; then frame 0x55 -> first valid has frame_err=1, data=0x3C. No valid while line is low (state WAIT_HIGH, busy=1). Second valid has data=0x55, frame_err=0.
- 1-cycle low glitch on idle line -> no valid; busy pulses then returns to 0 by e0+4.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valids 44 cycles apart, data 0x00 then 0xFF. Third frame with reset asserted at its data bit 3 -> all outputs 0 and no valid for that frame.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits LSB first, even parity, one stop bit
//
// Purpose: synchronises the serial line, checks the start, parity and stop
// bits, and presents each received byte with a one-cycle valid strobe and
// error flags.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_rx           serial line, idle high, asynchronous to i_clk
//   o_data         last received byte (held until the next valid)
//   o_valid        one-cycle pulse when a frame completes
//   o_parity_err   parity mismatch on the last frame
//   o_frame_err    stop bit sampled low on the last frame
//   o_busy         high whenever the receiver is not idle
module uart_rx #(
  parameter int CLK_FREQ  = 50000,
  parameter int BAUD_RATE = 10000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int N    = 2 * (CLK_FREQ / (BAUD_RATE * 2));
  localparam int HALF = N / 2;
  localparam int CW   = $clog2(N);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          r_sync1;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          r_busy;

  // Both flops reset high so that leaving reset never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_shift      <= 8'd0;
      r_par        <= 1'b0;
      r_data       <= 8'd0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the line half a bit in; a short low pulse is a glitch.
        S_START: begin
          if (r_cnt == CNT_MID) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_idx   <= 3'd0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Counting from mid-start, every N clocks lands mid-bit.
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_PARITY;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Even parity: received bit XOR data bits is 1 on mismatch.
        S_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s ^ (^r_shift);
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Frames with errors still pulse valid; the flags qualify the byte.
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt        <= '0;
            r_data       <= r_shift;
            r_parity_err <= r_par;
            r_frame_err  <= ~r_rx_s;
            r_valid      <= 1'b1;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // A held-low (break) line must return high before a new start counts.
        S_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CLK_FREQ  = 50000;
  localparam int BAUD_RATE = 10000;
  localparam int N         = 2 * (CLK_FREQ / (BAUD_RATE * 2));
  localparam int HALF      = N / 2;
  localparam int LAT       = 2 + HALF + 10 * N;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks;
  int failures;
  int cyc;

  int         q_cyc[$];
  logic [7:0] q_data[$];
  logic       q_pe[$];
  logic       q_fe[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_parity_err(parity_err),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_data.push_back(data);
      q_pe.push_back(parity_err);
      q_fe.push_back(frame_err);
    end
  end

  task automatic clear_mon();
    q_cyc.delete();
    q_data.delete();
    q_pe.delete();
    q_fe.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            output int e0);
    logic [10:0] bits;
    bits = {stop, pbit, d, 1'b0};
    e0 = cyc + 1;
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    reset = 1'b1;
    rx    = 1'b1;
    idle(3);
    checks++; if (data !== 8'h00)     begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0)     begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_pe got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    clear_mon();
    busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen != 0)     begin failures++; $display("FAIL idle_busy cycles_high=%0d exp=0", busy_seen); end
    checks++; if (q_cyc.size() != 0)  begin failures++; $display("FAIL idle_valid count=%0d exp=0", q_cyc.size()); end
    checks++; if (data !== 8'h00)     begin failures++; $display("FAIL idle_data got=%h exp=00", data); end
  endtask

  task automatic test_frame_a5();
    int e0;
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b1, e0);
    idle(10);
    checks++; if (q_cyc.size() != 1) begin failures++; $display("FAIL a5_count got=%0d exp=1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      checks++; if (q_cyc[0] != e0 + LAT) begin failures++; $display("FAIL a5_time got=%0d exp=%0d", q_cyc[0] - e0, LAT); end
      checks++; if (q_data[0] !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", q_data[0]); end
      checks++; if (q_pe[0] !== 1'b0)    begin failures++; $display("FAIL a5_pe got=%b exp=0", q_pe[0]); end
      checks++; if (q_fe[0] !== 1'b0)    begin failures++; $display("FAIL a5_fe got=%b exp=0", q_fe[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL a5_busy got=%b exp=0", busy); end
  endtask

  task automatic test_parity();
    int e0;
    clear_mon();
    send_frame(8'h01, 1'b0, 1'b1, e0);
    idle(10);
    checks++; if (q_cyc.size() != 1) begin failures++; $display("FAIL par_count got=%0d exp=1", q_cyc.size()); end
    checks++; if (data !== 8'h01)     begin failures++; $display("FAIL par_data got=%h exp=01", data); end
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL par_fe got=%b exp=0", frame_err); end
    send_frame(8'h03, 1'b0, 1'b1, e0);
    idle(10);
    checks++; if (q_cyc.size() != 2) begin failures++; $display("FAIL par2_count got=%0d exp=2", q_cyc.size()); end
    checks++; if (data !== 8'h03)     begin failures++; $display("FAIL par2_data got=%h exp=03", data); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par2_err got=%b exp=0", parity_err); end
  endtask

  task automatic test_frame_err();
    int e0;
    int busy_low;
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, e0);
    busy_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
    end
    checks++; if (busy_low != 0)      begin failures++; $display("FAIL fe_busy cycles_low=%0d exp=0", busy_low); end
    checks++; if (q_cyc.size() != 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      checks++; if (q_data[0] !== 8'h3C) begin failures++; $display("FAIL fe_data got=%h exp=3c", q_data[0]); end
      checks++; if (q_fe[0] !== 1'b1)    begin failures++; $display("FAIL fe_flag got=%b exp=1", q_fe[0]); end
    end
    rx = 1'b1;
    idle(5);
    send_frame(8'h55, 1'b0, 1'b1, e0);
    idle(10);
    checks++; if (q_cyc.size() != 2) begin failures++; $display("FAIL fe2_count got=%0d exp=2", q_cyc.size()); end
    if (q_cyc.size() >= 2) begin
      checks++; if (q_data[1] !== 8'h55) begin failures++; $display("FAIL fe2_data got=%h exp=55", q_data[1]); end
      checks++; if (q_fe[1] !== 1'b0)    begin failures++; $display("FAIL fe2_flag got=%b exp=0", q_fe[1]); end
      checks++; if (q_cyc[1] != e0 + LAT) begin failures++; $display("FAIL fe2_time got=%0d exp=%0d", q_cyc[1] - e0, LAT); end
    end
  endtask

  task automatic test_glitch();
    int e0;
    clear_mon();
    e0 = cyc + 1;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    while (cyc < e0 + 2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
    while (cyc < e0 + 2 + HALF) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
    idle(60);
    checks++; if (q_cyc.size() != 0) begin failures++; $display("FAIL glitch_valid count=%0d exp=0", q_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int e0a;
    int e0b;
    clear_mon();
    send_frame(8'h00, 1'b0, 1'b1, e0a);
    send_frame(8'hFF, 1'b0, 1'b1, e0b);
    idle(10);
    checks++; if (q_cyc.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", q_cyc.size()); end
    if (q_cyc.size() >= 2) begin
      checks++; if (q_cyc[1] - q_cyc[0] != 11 * N) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", q_cyc[1] - q_cyc[0], 11 * N); end
      checks++; if (q_data[0] !== 8'h00) begin failures++; $display("FAIL b2b_data0 got=%h exp=00", q_data[0]); end
      checks++; if (q_data[1] !== 8'hFF) begin failures++; $display("FAIL b2b_data1 got=%h exp=ff", q_data[1]); end
    end
    // Third frame: start bit and data bits 0..2, then reset inside bit 3.
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (N) @(negedge clk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", data); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", valid); end
    idle(5);
    reset = 1'b0;
    idle(100);
    checks++; if (q_cyc.size() != 2) begin failures++; $display("FAIL rst_mid_count got=%0d exp=2", q_cyc.size()); end
    checks++; if (data !== 8'h00)     begin failures++; $display("FAIL rst_after_data got=%h exp=00", data); end
  endtask

  task automatic test_random();
    int         e_cyc[$];
    logic [7:0] e_data[$];
    logic       e_pe[$];
    logic       e_fe[$];
    int         e0;
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    int         bad;
    clear_mon();
    for (int f = 0; f < 12; f++) begin
      d    = 8'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, stop, e0);
      e_cyc.push_back(e0 + LAT);
      e_data.push_back(d);
      e_pe.push_back(pbit != (^d));
      e_fe.push_back(!stop);
      if (!stop) begin
        idle($urandom_range(0, 15));
        rx = 1'b1;
        idle($urandom_range(3, 8));
      end else begin
        idle($urandom_range(0, 6));
      end
    end
    idle(60);
    checks++; if (q_cyc.size() != e_cyc.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", q_cyc.size(), e_cyc.size()); end
    bad = 0;
    for (int i = 0; i < e_cyc.size() && i < q_cyc.size(); i++) begin
      if (q_cyc[i] != e_cyc[i] || q_data[i] !== e_data[i] || q_pe[i] !== e_pe[i] || q_fe[i] !== e_fe[i]) begin
        bad++;
        $display("FAIL rnd_frame%0d got t=%0d d=%h pe=%b fe=%b exp t=%0d d=%h pe=%b fe=%b",
                 i, q_cyc[i], q_data[i], q_pe[i], q_fe[i], e_cyc[i], e_data[i], e_pe[i], e_fe[i]);
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_frames bad=%0d exp=0", bad); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset    = 1'b1;
    rx       = 1'b1;
    test_reset();
    test_frame_a5();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
